reg_write_sequencer: RTL and testbench

Command front-end for the three-entry 8-bit register file. It accepts single-register write commands and whole-file FILL/CLEAR commands over a valid/ready handshake and buffers them in a small FIFO. It sequences them into the register file's single write port (`write_enable`, `write_address`, `write_data`), issuing at most one write per cycle. Illegal commands are dropped and counted.

---
 rtl/reg_seq_pkg.sv | 38 +++
 rtl/cmd_fifo.sv | 89 ++++++++
 rtl/reg_write_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reg_write_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_seq_pkg
//   Definitions shared by the register write sequencer and its command FIFO:
//   opcode encodings, FSM state type, the packed command record and a
//   saturating-increment helper for the error counter.
// -----------------------------------------------------------------------------
package reg_seq_pkg;

  localparam int ADDR_W = 2;  // register file address width
  localparam int DATA_W = 8;  // register file data width
  localparam int ERR_W  = 8;  // dropped-command counter width

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
//   Circular-buffer FIFO with wrapping read/write pointers and an explicit
//   occupancy counter. Head data is presented combinationally (show-ahead).
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   push           write push_data when not full (ignored when full)
//   push_data      WIDTH-bit entry to store
//   pop            discard head entry when not empty (ignored when empty)
//   pop_data       current head entry
//   full, empty    status derived from the registered level only
//   level          number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q,  level_d;
  logic             push_ok, pop_ok;

  // Status comes from the registered level only, so cmd_ready upstream never
  // depends combinationally on a same-cycle pop.
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop  && !empty;

  // NOTE: every variable is given a default before any branch so that no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;  // idle, or push and pop cancel out
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order between blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM/regs
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/reg_write_sequencer.sv
// -----------------------------------------------------------------------------
// reg_write_sequencer
//   Command front-end for a small register file. Accepts WRITE / FILL / CLEAR
//   commands over valid/ready, buffers them in cmd_fifo and sequences them
//   into the single registered write port, at most one write per cycle.
//   FILL/CLEAR sweep addresses 0..NUM_REGS-1 on consecutive cycles. Illegal
//   commands (WRITE to an out-of-range address, reserved opcode) are dropped
//   and counted in a saturating error counter.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   cmd_valid / cmd_ready           command handshake (ready = FIFO not full)
//   cmd_op, cmd_addr, cmd_data      command fields
//   write_enable/_address/_data     registered register-file write port
//   busy                            sweep in progress or commands pending
//   fifo_level                      entries held in the command FIFO
//   err_count                       dropped commands, saturates at 255
// -----------------------------------------------------------------------------
module reg_write_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DEPTH    = 4,  // power of two, >= 2
  parameter int NUM_REGS = 3   // 1..4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      write_address,
  output logic [DATA_W-1:0]      write_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [ERR_W-1:0]       err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             push_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign push_cmd = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_data};
  assign head     = cmd_t'(head_raw);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cmd_ready = !fifo_full;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e            state_q,      state_d;
  logic [ADDR_W-1:0] sweep_cnt_q,  sweep_cnt_d;   // next address to sweep
  logic [DATA_W-1:0] sweep_data_q, sweep_data_d;  // data for the whole sweep
  logic              wen_q,        wen_d;
  logic [ADDR_W-1:0] waddr_q,      waddr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [ERR_W-1:0]  err_q,        err_d;

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    sweep_data_d = sweep_data_q;
    wen_d        = 1'b0;      // strobe: low unless a write is issued
    waddr_d      = waddr_q;   // address/data hold between writes
    wdata_d      = wdata_q;
    err_d        = err_q;
    pop          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          unique case (head.op)
            OP_WRITE: begin
              if (head.addr <= LAST_ADDR) begin
                wen_d   = 1'b1;
                waddr_d = head.addr;
                wdata_d = head.data;
              end else begin
                err_d = sat_inc(err_q);
              end
            end
            OP_FILL, OP_CLEAR: begin
              // Address 0 is issued on the pop edge itself, so the sweep
              // continues from address 1 and costs exactly NUM_REGS cycles.
              sweep_data_d = (head.op == OP_FILL) ? head.data : '0;
              wen_d        = 1'b1;
              waddr_d      = '0;
              wdata_d      = sweep_data_d;
              sweep_cnt_d  = ADDR_ONE;
              if (LAST_ADDR != '0) state_d = ST_SWEEP;
            end
            default: begin
              err_d = sat_inc(err_q);
            end
          endcase
        end
      end

      ST_SWEEP: begin
        // No pop here; the next command is popped on the edge after the
        // final sweep write, leaving no idle gap.
        wen_d       = 1'b1;
        waddr_d     = sweep_cnt_q;
        wdata_d     = sweep_data_q;
        sweep_cnt_d = sweep_cnt_q + ADDR_ONE;
        if (sweep_cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sweep_cnt_q  <= '0;
      sweep_data_q <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_data_q <= sweep_data_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  assign write_enable  = wen_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign err_count     = err_q;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_write_sequencer
//   Self-checking bench. A queue-based reference model predicts the write
//   port, FIFO level, ready, busy and error count on every cycle; directed
//   scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_reg_write_sequencer;
  import reg_seq_pkg::*;

  localparam int DEPTH    = 4;
  localparam int NUM_REGS = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       write_enable;
  logic [1:0] write_address;
  logic [7:0] write_data;
  logic       busy;
  logic [2:0] fifo_level;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  reg_write_sequencer #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .err_count     (err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending commands in a queue, a sweep as a count of
  // remaining writes.
  // ---------------------------------------------------------------------------
  cmd_t       m_q[$];
  int         m_sweep_left;
  int         m_sweep_addr;
  logic [7:0] m_sweep_data;
  logic       m_wen;
  logic [1:0] m_waddr;
  logic [7:0] m_wdata;
  int         m_err;

  function automatic void model_reset();
    m_q.delete();
    m_sweep_left = 0;
    m_sweep_addr = 0;
    m_sweep_data = '0;
    m_wen        = 1'b0;
    m_waddr      = '0;
    m_wdata      = '0;
    m_err        = 0;
  endfunction

  // One rising edge; returns whether the offered command was accepted.
  function automatic bit model_step(input bit v, input logic [1:0] op,
                                    input logic [1:0] addr, input logic [7:0] d);
    bit   acc;
    cmd_t c;
    acc   = v && (m_q.size() < DEPTH);
    m_wen = 1'b0;
    if (m_sweep_left > 0) begin
      m_wen   = 1'b1;
      m_waddr = 2'(m_sweep_addr);
      m_wdata = m_sweep_data;
      m_sweep_addr++;
      m_sweep_left--;
    end else if (m_q.size() > 0) begin
      c = m_q.pop_front();
      if (c.op == OP_WRITE && int'(c.addr) < NUM_REGS) begin
        m_wen   = 1'b1;
        m_waddr = c.addr;
        m_wdata = c.data;
      end else if (c.op == OP_FILL || c.op == OP_CLEAR) begin
        m_sweep_data = (c.op == OP_FILL) ? c.data : 8'h00;
        m_wen        = 1'b1;
        m_waddr      = 2'd0;
        m_wdata      = m_sweep_data;
        m_sweep_addr = 1;
        m_sweep_left = NUM_REGS - 1;
      end else if (m_err < 255) begin
        m_err++;
      end
    end
    if (acc) m_q.push_back('{op: op_e'(op), addr: addr, data: d});
    return acc;
  endfunction

  // Compare process: every falling edge, DUT outputs against the model.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("write_enable",  write_enable,  m_wen);
      check("write_address", write_address, m_waddr);
      check("write_data",    write_data,    m_wdata);
      check("fifo_level",    fifo_level,    m_q.size());
      check("cmd_ready",     cmd_ready,     m_q.size() < DEPTH);
      check("busy",          busy,          (m_sweep_left > 0) || (m_q.size() > 0));
      check("err_count",     err_count,     m_err);
    end
  end

  // Downstream register file fed from the DUT write port.
  logic [7:0] rf [4];
  always @(posedge clk) begin
    if (reset_n && write_enable) rf[write_address] <= write_data;
  end

  // One cycle of stimulus; called just after a falling edge.
  task automatic cycle(input bit v, input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] d, output bit acc);
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = d;
    @(posedge clk);
    acc = model_step(v, op, addr, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 2'd0, 8'h00, acc);
  endtask

  // Holds a command until accepted (bounded); returns the number of offers.
  task automatic offer(input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] d, output int tries);
    bit acc;
    tries = 0;
    do begin
      cycle(1'b1, op, addr, d, acc);
      tries++;
    end while (!acc && tries < 32);
  endtask

  initial begin
    bit         acc;
    int         tries;
    int         accepted;
    int         wcount;
    logic [1:0] rop;
    logic [10:0] exp_seq [5];

    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready",    cmd_ready,    1);
    check("rst_busy",         busy,         0);
    check("rst_write_enable", write_enable, 0);
    check("rst_fifo_level",   fifo_level,   0);
    reset_n = 1'b1;

    // --- Single WRITE: write appears two edges after acceptance -------------
    cycle(1'b1, OP_WRITE, 2'd2, 8'hA5, acc);
    check("t1_accepted", acc, 1);
    check("t1_wen_at_accept", write_enable, 0);
    idle(1);
    check("t1_wen",  write_enable,  1);
    check("t1_addr", write_address, 2);
    check("t1_data", write_data,    8'hA5);
    idle(1);
    check("t1_wen_after", write_enable, 0);
    check("t1_rf2",       rf[2],        8'hA5);

    // --- FILL then WRITE back-to-back --------------------------------------
    exp_seq[0] = {1'b1, 2'd0, 8'h3C};
    exp_seq[1] = {1'b1, 2'd1, 8'h3C};
    exp_seq[2] = {1'b1, 2'd2, 8'h3C};
    exp_seq[3] = {1'b1, 2'd1, 8'h11};
    exp_seq[4] = {1'b0, 2'd1, 8'h11};
    cycle(1'b1, OP_FILL, 2'd0, 8'h3C, acc);
    cycle(1'b1, OP_WRITE, 2'd1, 8'h11, acc);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_seq%0d", i), {write_enable, write_address, write_data}, exp_seq[i]);
      idle(1);
    end
    check("t2_rf0", rf[0], 8'h3C);
    check("t2_rf1", rf[1], 8'h11);
    check("t2_rf2", rf[2], 8'h3C);

    // --- Fill the FIFO while sweeps stall the pops -------------------------
    offer(OP_FILL,  2'd0, 8'h55, tries); check("t3_f1_tries", tries, 1);
    offer(OP_FILL,  2'd0, 8'hAA, tries); check("t3_f2_tries", tries, 1);
    offer(OP_WRITE, 2'd0, 8'h01, tries); check("t3_w1_tries", tries, 1);
    offer(OP_WRITE, 2'd1, 8'h02, tries); check("t3_w2_tries", tries, 1);
    offer(OP_WRITE, 2'd2, 8'h03, tries); check("t3_w3_tries", tries, 1);
    offer(OP_WRITE, 2'd0, 8'h04, tries); check("t3_w4_tries", tries, 1);
    check("t3_level_full", fifo_level, 4);
    check("t3_ready_low",  cmd_ready,  0);
    offer(OP_WRITE, 2'd1, 8'h05, tries); check("t3_w5_tries", tries, 3);
    idle(12);
    check("t3_busy_drained",  busy,       0);
    check("t3_level_drained", fifo_level, 0);

    // --- Illegal commands ---------------------------------------------------
    cycle(1'b1, OP_WRITE, 2'd3, 8'hEE, acc);
    idle(1);
    check("t4_wen_bad_addr", write_enable, 0);
    check("t4_err1",         err_count,    1);
    cycle(1'b1, OP_RSVD, 2'd0, 8'h00, acc);
    idle(1);
    check("t4_wen_rsvd", write_enable, 0);
    check("t4_err2",     err_count,    2);

    // --- Steady push+pop at level 2 -----------------------------------------
    cycle(1'b1, OP_FILL, 2'd0, 8'h77, acc);
    idle(1);
    cycle(1'b1, OP_WRITE, 2'd0, 8'h10, acc);
    cycle(1'b1, OP_WRITE, 2'd1, 8'h20, acc);
    check("t5_level_start", fifo_level, 2);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, OP_WRITE, 2'($urandom_range(0, 2)), 8'($urandom), acc);
      check($sformatf("t5_accept%0d", i), acc, 1);
      check($sformatf("t5_level%0d", i), fifo_level, 2);
    end
    idle(6);

    // --- Randomized traffic -------------------------------------------------
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      rop = (r < 5) ? OP_WRITE : (r < 7) ? OP_FILL : (r < 9) ? OP_CLEAR : OP_RSVD;
      cycle($urandom_range(0, 3) != 0, rop, 2'($urandom_range(0, 3)), 8'($urandom), acc);
    end
    idle(30);

    // --- Error counter saturation -------------------------------------------
    accepted = 0;
    for (int i = 0; i < 2000 && accepted < 256; i++) begin
      cycle(1'b1, (i % 2 == 1) ? OP_RSVD : OP_WRITE, 2'd3, 8'h00, acc);
      if (acc) accepted++;
    end
    check("t7_accepted", accepted, 256);
    idle(10);
    check("t7_err_sat", err_count, 255);

    // --- Reset during the second cycle of a CLEAR ---------------------------
    cycle(1'b1, OP_CLEAR, 2'd0, 8'h00, acc);
    cycle(1'b1, OP_WRITE, 2'd0, 8'h99, acc);
    @(posedge clk);
    acc = model_step(1'b0, 2'd0, 2'd0, 8'h00);
    #2;
    check("t8_wen_pre",  write_enable,  1);
    check("t8_addr_pre", write_address, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t8_wen_rst",   write_enable, 0);
    check("t8_level_rst", fifo_level,   0);
    check("t8_busy_rst",  busy,         0);
    check("t8_err_rst",   err_count,    0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (write_enable) wcount++;
    end
    check("t8_no_writes", wcount, 0);
    check("t8_rf2_kept",  rf[2],  rf[0] == 8'h00 ? rf[2] : rf[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
